// File: rtl/rv_structs.sv
// rtl/rv_structs.sv - shared types and constants for the reservation-station ALU pool
package rv_structs;

  localparam int RS_DEF_XLEN  = 32;
  localparam int RS_DEF_TAG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Width-independent part of an entry; tags and values live in parameter-sized arrays.
  typedef struct packed {
    logic    busy;
    alu_op_t op;
    logic    s1_rdy;
    logic    s2_rdy;
  } rs_alu_entry_t;

endpackage

// File: rtl/rs_pool_alu.sv
// rtl/rs_pool_alu.sv - combinational integer ALU used by the reservation-station pool
module rs_pool_alu
  import rv_structs::*;
#(
  parameter int XLEN = RS_DEF_XLEN
) (
  input  alu_op_t          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rs_alu_pool.sv
// rtl/rs_alu_pool.sv - reservation-station pool with oldest-first issue to one ALU
// Optional dispatch-cycle CDB forwarding: RS_ALU_POOL_DISP_BYPASS_EN
module rs_alu_pool
  import rv_structs::*;
#(
  parameter int DEPTH   = 8,
  parameter int XLEN    = RS_DEF_XLEN,
  parameter int TAG_W   = RS_DEF_TAG_W,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  alu_op_t                    disp_op,
  input  logic [TAG_W-1:0]           disp_dest,
  input  logic                       disp_s1_rdy,
  input  logic                       disp_s2_rdy,
  input  logic [XLEN-1:0]            disp_s1_val,
  input  logic [XLEN-1:0]            disp_s2_val,
  input  logic [TAG_W-1:0]           disp_s1_tag,
  input  logic [TAG_W-1:0]           disp_s2_tag,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_W-1:0]           res_tag,
  output logic [XLEN-1:0]            res_data,
  output logic [$clog2(DEPTH):0]     free_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  rs_alu_entry_t    ctl_q    [DEPTH];
  rs_alu_entry_t    ctl_d    [DEPTH];
  logic [TAG_W-1:0] dest_q   [DEPTH];
  logic [TAG_W-1:0] dest_d   [DEPTH];
  logic [TAG_W-1:0] s1_tag_q [DEPTH];
  logic [TAG_W-1:0] s1_tag_d [DEPTH];
  logic [TAG_W-1:0] s2_tag_q [DEPTH];
  logic [TAG_W-1:0] s2_tag_d [DEPTH];
  logic [XLEN-1:0]  s1_val_q [DEPTH];
  logic [XLEN-1:0]  s1_val_d [DEPTH];
  logic [XLEN-1:0]  s2_val_q [DEPTH];
  logic [XLEN-1:0]  s2_val_d [DEPTH];
  logic [DEPTH-1:0] age_q    [DEPTH];
  logic [DEPTH-1:0] age_d    [DEPTH];

  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [XLEN-1:0]  res_data_q, res_data_d;
  logic [CW-1:0]    free_count_q, free_count_d;

  logic [DEPTH-1:0] busy, elig, sel;
  logic             issue, disp_fire;
  logic [IW-1:0]    alloc_idx;
  alu_op_t          sel_op;
  logic [XLEN-1:0]  sel_a, sel_b, alu_y;
  logic [TAG_W-1:0] sel_dest;
  logic             d1_rdy, d2_rdy;
  logic [XLEN-1:0]  d1_val, d2_val;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i] = ctl_q[i].busy;
      elig[i] = ctl_q[i].busy && ctl_q[i].s1_rdy && ctl_q[i].s2_rdy;
    end
  end

  // Age matrix is a total order over busy entries, so sel is at most one-hot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
    issue = (|elig) && (!res_valid_q || res_ready);
  end

  always_comb begin
    sel_op   = ALU_ADD;
    sel_a    = '0;
    sel_b    = '0;
    sel_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_op   = ctl_q[i].op;
        sel_a    = s1_val_q[i];
        sel_b    = s2_val_q[i];
        sel_dest = dest_q[i];
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = IW'(i);
    end
  end

  assign disp_ready = (free_count_q != '0);
  assign disp_fire  = disp_valid && disp_ready;

  always_comb begin
    d1_rdy = disp_s1_rdy;
    d1_val = disp_s1_val;
    d2_rdy = disp_s2_rdy;
    d2_val = disp_s2_val;
`ifdef RS_ALU_POOL_DISP_BYPASS_EN
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (!disp_s1_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_s1_tag) begin
        d1_rdy = 1'b1;
        d1_val = cdb_data[c*XLEN +: XLEN];
      end
      if (!disp_s2_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_s2_tag) begin
        d2_rdy = 1'b1;
        d2_val = cdb_data[c*XLEN +: XLEN];
      end
    end
`endif
  end

  rs_pool_alu #(.XLEN(XLEN)) u_alu (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (alu_y)
  );

  always_comb begin
    ctl_d    = ctl_q;
    dest_d   = dest_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    age_d    = age_q;

    // Descending bus scan so the lowest-index matching bus is the one that sticks.
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (ctl_q[i].busy && !ctl_q[i].s1_rdy && cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == s1_tag_q[i]) begin
          ctl_d[i].s1_rdy = 1'b1;
          s1_val_d[i]     = cdb_data[c*XLEN +: XLEN];
        end
        if (ctl_q[i].busy && !ctl_q[i].s2_rdy && cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == s2_tag_q[i]) begin
          ctl_d[i].s2_rdy = 1'b1;
          s2_val_d[i]     = cdb_data[c*XLEN +: XLEN];
        end
      end
      if (issue && sel[i]) ctl_d[i].busy = 1'b0;
    end

    if (disp_fire) begin
      ctl_d[alloc_idx]    = '{busy: 1'b1, op: disp_op, s1_rdy: d1_rdy, s2_rdy: d2_rdy};
      dest_d[alloc_idx]   = disp_dest;
      s1_tag_d[alloc_idx] = disp_s1_tag;
      s2_tag_d[alloc_idx] = disp_s2_tag;
      s1_val_d[alloc_idx] = d1_val;
      s2_val_d[alloc_idx] = d2_val;
      age_d[alloc_idx]    = '0;
      for (int j = 0; j < DEPTH; j++) age_d[j][alloc_idx] = busy[j];
    end

    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_tag_d   = sel_dest;
      res_data_d  = alu_y;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    free_count_d = free_count_q + CW'(issue) - CW'(disp_fire);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl_d[i].busy = 1'b0;
        age_d[i]      = '0;
      end
      res_valid_d  = 1'b0;
      free_count_d = CW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl_q[i] <= '0;
        age_q[i] <= '0;
      end
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_data_q   <= '0;
      free_count_q <= CW'(DEPTH);
    end else begin
      ctl_q        <= ctl_d;
      age_q        <= age_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
      res_data_q   <= res_data_d;
      free_count_q <= free_count_d;
    end
  end

  // Payload is qualified by busy/rdy, so it needs no reset.
  always_ff @(posedge clk) begin
    dest_q   <= dest_d;
    s1_tag_q <= s1_tag_d;
    s2_tag_q <= s2_tag_d;
    s1_val_q <= s1_val_d;
    s2_val_q <= s2_val_d;
  end

  assign res_valid  = res_valid_q;
  assign res_tag    = res_tag_q;
  assign res_data   = res_data_q;
  assign free_count = free_count_q;

endmodule

// File: tb/tb_rs_alu_pool.sv
// tb/tb_rs_alu_pool.sv - self-checking bench for rs_alu_pool against a behavioural model
module tb_rs_alu_pool;
  import rv_structs::*;

  localparam int DEPTH   = 8;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int NUM_CDB = 2;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  alu_op_t     disp_op;
  logic [4:0]  disp_dest, disp_s1_tag, disp_s2_tag;
  logic        disp_s1_rdy, disp_s2_rdy;
  logic [31:0] disp_s1_val, disp_s2_val;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        res_valid, res_ready;
  logic [4:0]  res_tag;
  logic [31:0] res_data;
  logic [3:0]  free_count;

  always #5 clk = ~clk;

  rs_alu_pool #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
    .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
    .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
    .free_count(free_count)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a bag of entries stamped with a dispatch sequence number; oldest = smallest stamp.
  bit          m_busy [DEPTH];
  alu_op_t     m_op   [DEPTH];
  logic [4:0]  m_dest [DEPTH];
  bit          m_r1   [DEPTH];
  bit          m_r2   [DEPTH];
  logic [4:0]  m_t1   [DEPTH];
  logic [4:0]  m_t2   [DEPTH];
  logic [31:0] m_v1   [DEPTH];
  logic [31:0] m_v2   [DEPTH];
  int          m_seq  [DEPTH];
  int          seq_ctr = 0;
  bit          m_res_valid = 1'b0;
  logic [4:0]  m_res_tag;
  logic [31:0] m_res_data;
  int          best, alloc, hit;

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int cdb_hit(logic [4:0] t);
    for (int c = 0; c < NUM_CDB; c++)
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) return c;
    return -1;
  endfunction

  function automatic logic [31:0] ref_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int s = int'(b[4:0]);
    logic [31:0] ones = 32'hFFFF_FFFF;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << s;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_res_valid = 1'b0;
      if (!rst) begin
        m_res_tag  = 5'd0;
        m_res_data = 32'd0;
      end
    end else begin
      best = -1;
      for (int i = 0; i < DEPTH; i++)
        if (m_busy[i] && m_r1[i] && m_r2[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
      alloc = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && alloc < 0) alloc = i;
      if (best >= 0 && (!m_res_valid || res_ready)) begin
        m_res_valid  = 1'b1;
        m_res_tag    = m_dest[best];
        m_res_data   = ref_alu(m_op[best], m_v1[best], m_v2[best]);
        m_busy[best] = 1'b0;
      end else if (res_ready) begin
        m_res_valid = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && !m_r1[i]) begin
          hit = cdb_hit(m_t1[i]);
          if (hit >= 0) begin m_r1[i] = 1'b1; m_v1[i] = cdb_data[hit*XLEN +: XLEN]; end
        end
        if (m_busy[i] && !m_r2[i]) begin
          hit = cdb_hit(m_t2[i]);
          if (hit >= 0) begin m_r2[i] = 1'b1; m_v2[i] = cdb_data[hit*XLEN +: XLEN]; end
        end
      end
      if (disp_valid && alloc >= 0) begin
        m_busy[alloc] = 1'b1;
        m_op[alloc]   = disp_op;
        m_dest[alloc] = disp_dest;
        m_r1[alloc]   = disp_s1_rdy;
        m_r2[alloc]   = disp_s2_rdy;
        m_t1[alloc]   = disp_s1_tag;
        m_t2[alloc]   = disp_s2_tag;
        m_v1[alloc]   = disp_s1_val;
        m_v2[alloc]   = disp_s2_val;
`ifdef RS_ALU_POOL_DISP_BYPASS_EN
        hit = cdb_hit(disp_s1_tag);
        if (!disp_s1_rdy && hit >= 0) begin m_r1[alloc] = 1'b1; m_v1[alloc] = cdb_data[hit*XLEN +: XLEN]; end
        hit = cdb_hit(disp_s2_tag);
        if (!disp_s2_rdy && hit >= 0) begin m_r2[alloc] = 1'b1; m_v2[alloc] = cdb_data[hit*XLEN +: XLEN]; end
`endif
        m_seq[alloc] = seq_ctr;
        seq_ctr++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_res_valid", 32'(res_valid), 32'(m_res_valid));
      check("model_free_count", 32'(free_count), 32'(m_free()));
      check("model_disp_ready", 32'(disp_ready), 32'(m_free() != 0));
      if (m_res_valid) begin
        check("model_res_tag", 32'(res_tag), 32'(m_res_tag));
        check("model_res_data", res_data, m_res_data);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 2'b00;
    flush      = 1'b0;
  endtask

  task automatic set_disp(alu_op_t op, logic [4:0] dest,
                          bit r1, logic [31:0] v1, logic [4:0] t1,
                          bit r2, logic [31:0] v2, logic [4:0] t2);
    disp_valid  = 1'b1;
    disp_op     = op;
    disp_dest   = dest;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic run_op(string name, alu_op_t op, logic [31:0] a, logic [31:0] b,
                        logic [4:0] dest, logic [31:0] exp);
    set_disp(op, dest, 1'b1, a, 5'd0, 1'b1, b, 5'd0);
    step();
    disp_valid = 1'b0;
    step();
    check({name, "_valid"}, 32'(res_valid), 32'd1);
    check({name, "_tag"}, 32'(res_tag), 32'(dest));
    check({name, "_data"}, res_data, exp);
  endtask

  initial begin
    rst = 1'b0; res_ready = 1'b1;
    idle();
    set_disp(ALU_ADD, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
    step(); step();
    chk_en = 1'b1;
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_tag", 32'(res_tag), 32'd0);
    check("reset_res_data", res_data, 32'd0);
    check("reset_free_count", 32'(free_count), 32'd8);
    check("reset_disp_ready", 32'(disp_ready), 32'd1);
    rst = 1'b1;

    set_disp(ALU_ADD, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    step();
    disp_valid = 1'b0;
    check("add_free_inflight", 32'(free_count), 32'd7);
    check("add_not_yet", 32'(res_valid), 32'd0);
    step();
    check("add_valid", 32'(res_valid), 32'd1);
    check("add_tag", 32'(res_tag), 32'd3);
    check("add_data", res_data, 32'd12);
    check("add_free_back", 32'(free_count), 32'd8);

    set_disp(ALU_SUB, 5'd6, 1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0);
    step();
    disp_valid = 1'b0;
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9}; cdb_data = {32'd0, 32'h20};
    step();
    cdb_valid = 2'b00;
    check("sub_wait", 32'(res_valid), 32'd0);
    step();
    check("sub_tag", 32'(res_tag), 32'd6);
    check("sub_data", res_data, 32'h1F);

    set_disp(ALU_ADD, 5'd7, 1'b0, 32'd0, 5'd25, 1'b1, 32'd0, 5'd0);
    step();
    disp_valid = 1'b0;
    cdb_valid = 2'b11; cdb_tag = {5'd25, 5'd25}; cdb_data = {32'd2, 32'd1};
    step();
    cdb_valid = 2'b00;
    step();
    check("cdb_prio_data", res_data, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      set_disp(ALU_ADD, 5'(i), 1'b0, 32'd0, 5'(10 + i), 1'b1, 32'd4, 5'd0);
      step();
    end
    disp_valid = 1'b0;
    check("full_free", 32'(free_count), 32'd0);
    check("full_ready", 32'(disp_ready), 32'd0);
    cdb_valid = 2'b10; cdb_tag = {5'd15, 5'd0}; cdb_data = {32'd3, 32'd0};
    step();
    cdb_valid = 2'b00;
    check("full_wake_ready", 32'(disp_ready), 32'd0);
    step();
    check("full_issue_ready", 32'(disp_ready), 32'd1);
    check("full_issue_free", 32'(free_count), 32'd1);
    check("full_issue_tag", 32'(res_tag), 32'd5);
    check("full_issue_data", res_data, 32'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_res_valid", 32'(res_valid), 32'd0);
    check("flush_free", 32'(free_count), 32'd8);

    set_disp(ALU_ADD, 5'd1, 1'b0, 32'd0, 5'd20, 1'b1, 32'd1, 5'd0);
    step();
    set_disp(ALU_ADD, 5'd2, 1'b0, 32'd0, 5'd21, 1'b1, 32'd1, 5'd0);
    step();
    disp_valid = 1'b0;
    cdb_valid = 2'b11; cdb_tag = {5'd21, 5'd20}; cdb_data = {32'd200, 32'd100};
    step();
    cdb_valid = 2'b00;
    res_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      check("hold_tag", 32'(res_tag), 32'd1);
      check("hold_data", res_data, 32'd101);
      check("hold_free", 32'(free_count), 32'd7);
      step();
    end
    res_ready = 1'b1;
    step();
    check("second_tag", 32'(res_tag), 32'd2);
    check("second_data", res_data, 32'd201);

    run_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 5'd4, 32'hF800_0000);
    run_op("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd5, 32'd1);
    run_op("slt", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd6, 32'd0);
    run_op("sll", ALU_SLL, 32'h0000_0003, 32'd33, 5'd7, 32'h0000_0006);

`ifdef RS_ALU_POOL_DISP_BYPASS_EN
    set_disp(ALU_ADD, 5'd8, 1'b0, 32'd0, 5'd30, 1'b1, 32'd5, 5'd0);
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd30}; cdb_data = {32'd0, 32'd10};
    step();
    idle();
    step();
    check("bypass_valid", 32'(res_valid), 32'd1);
    check("bypass_data", res_data, 32'd15);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      disp_valid  = ($urandom_range(0, 1) == 1);
      disp_op     = alu_op_t'(4'($urandom_range(0, 9)));
      disp_dest   = 5'($urandom_range(0, 31));
      disp_s1_rdy = ($urandom_range(0, 1) == 1);
      disp_s2_rdy = ($urandom_range(0, 1) == 1);
      disp_s1_tag = 5'($urandom_range(0, 7));
      disp_s2_tag = 5'($urandom_range(0, 7));
      disp_s1_val = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      disp_s2_val = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      cdb_valid   = 2'($urandom_range(0, 3));
      cdb_tag     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cdb_data    = {$urandom, $urandom};
      res_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    rst = 1'b1;
    res_ready = 1'b1;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
